// File: rtl/ife_scan_ctrl.sv
// Raster-scan sequencer for the IFE filter: fetches each KxK window from image ROM,
// streams it to the datapath with border zero-padding, then writes the result back.
// Optional cycle counter output perf_cycles is enabled by defining IFE_SCAN_PERF_EN.
module ife_scan_ctrl #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    input  logic [1:0]        sel,
    output logic [1:0]        sel_q,
    output logic [ADDR_W-1:0] iaddr,
    input  logic [7:0]        idata,
    output logic              pix_vld,
    output logic [7:0]        pix_data,
    output logic              pix_pad,
    output logic              win_start,
    output logic              win_last,
    input  logic              res_vld,
    input  logic [7:0]        res_data,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data_wr,
    output logic              wen
`ifdef IFE_SCAN_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StWaitRes,
        StWrite
    } state_e;

    state_e state_q, state_d;

    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic signed [2:0] dy_q, dx_q, rad;
    logic [ADDR_W-1:0] iaddr_q, off_addr, pix_addr;
    logic              off_pad, off_first, off_last, pix_done;
    int                row_off, col_off;

    // Window offset decode; border tests are done on signed coordinates.
    always_comb begin
        rad       = (sel_q == 2'd0) ? 3'sd1 : 3'sd2;
        row_off   = int'(row_q) + int'(dy_q);
        col_off   = int'(col_q) + int'(dx_q);
        off_pad   = (row_off < 0) || (row_off >= IMG_H) || (col_off < 0) || (col_off >= IMG_W);
        off_addr  = ADDR_W'(row_off * IMG_W + col_off);
        pix_addr  = ADDR_W'(int'(row_q) * IMG_W + int'(col_q));
        off_first = (dy_q == -rad) && (dx_q == -rad);
        off_last  = (dy_q == rad) && (dx_q == rad);
        pix_done  = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
        // Padded offsets leave the ROM address where it was.
        iaddr     = (state_q == StFetch && !off_pad) ? off_addr : iaddr_q;
        pix_data  = (pix_vld && !pix_pad) ? idata : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (ready) state_d = StFetch;
            StFetch:   if (off_last) state_d = StDrain;
            StDrain:   state_d = StWaitRes;
            StWaitRes: if (res_vld) state_d = StWrite;
            StWrite:   state_d = pix_done ? StIdle : StFetch;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
        wen  = (state_q == StWrite);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q     <= 2'd0;
            row_q     <= '0;
            col_q     <= '0;
            dy_q      <= '0;
            dx_q      <= '0;
            iaddr_q   <= '0;
            pix_vld   <= 1'b0;
            pix_pad   <= 1'b0;
            win_start <= 1'b0;
            win_last  <= 1'b0;
            addr      <= '0;
            data_wr   <= 8'd0;
        end else begin
            iaddr_q   <= iaddr;
            // Strobe for each offset trails its fetch by one cycle, aligned with idata.
            pix_vld   <= (state_q == StFetch);
            pix_pad   <= (state_q == StFetch) && off_pad;
            win_start <= (state_q == StFetch) && off_first;
            win_last  <= (state_q == StFetch) && off_last;
            case (state_q)
                StIdle: begin
                    if (ready) begin
                        sel_q <= sel;
                        row_q <= '0;
                        col_q <= '0;
                        dy_q  <= (sel == 2'd0) ? -3'sd1 : -3'sd2;
                        dx_q  <= (sel == 2'd0) ? -3'sd1 : -3'sd2;
                    end
                end
                StFetch: begin
                    if (dx_q == rad) begin
                        dx_q <= -rad;
                        dy_q <= dy_q + 3'sd1;
                    end else begin
                        dx_q <= dx_q + 3'sd1;
                    end
                end
                StWaitRes: begin
                    if (res_vld) begin
                        addr    <= pix_addr;
                        data_wr <= res_data;
                    end
                end
                StWrite: begin
                    dy_q <= -rad;
                    dx_q <= -rad;
                    if (col_q == CW'(IMG_W - 1)) begin
                        col_q <= '0;
                        row_q <= row_q + RW'(1);
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IFE_SCAN_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= 32'd0;
        end else if (state_q == StIdle && ready) begin
            perf_cycles <= 32'd0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ife_scan_ctrl.sv
// Bench for ife_scan_ctrl on an 8x8 image: time-indexed window/write model, reactive
// mean-filter datapath, ROM model, plus literal address/padding expectations.
module tb_ife_scan_ctrl;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NPIX = W * H;

    logic       clk, reset, ready, busy;
    logic [1:0] sel, sel_q;
    logic [5:0] iaddr, addr;
    logic [7:0] idata, pix_data, res_data, data_wr;
    logic       pix_vld, pix_pad, win_start, win_last, res_vld, wen;
`ifdef IFE_SCAN_PERF_EN
    logic [31:0] perf_cycles;
`endif

    ife_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy), .sel(sel), .sel_q(sel_q),
        .iaddr(iaddr), .idata(idata), .pix_vld(pix_vld), .pix_data(pix_data),
        .pix_pad(pix_pad), .win_start(win_start), .win_last(win_last), .res_vld(res_vld),
        .res_data(res_data), .addr(addr), .data_wr(data_wr), .wen(wen)
`ifdef IFE_SCAN_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] img [NPIX];
    logic [7:0] mem [NPIX];

    always @(posedge clk) idata <= img[iaddr];

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int t = 0;
    bit run_on = 0, done = 0;
    logic [1:0] cur_sel = 2'd0;
    int cur_k = 3, cur_dly = 0;
    bit cur_stray = 0, cur_f5a = 0;
    int wcount, w20, w27, pad0, pad63, last_ia;
    int q0[$], q27[$];
    // Datapath model state
    bit pend = 0;
    int cnt, acc, sidx, widx, fire_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Address of offset k of a ks x ks window centred on pixel p, or -1 if outside.
    function automatic int win_addr(input int p, input int ks, input int k);
        int yy, xx;
        yy = p / W + k / ks - ks / 2;
        xx = p % W + k % ks - ks / 2;
        if (yy < 0 || yy >= H || xx < 0 || xx >= W) return -1;
        return yy * W + xx;
    endfunction

    function automatic logic [7:0] exp_res(input int p);
        int s, a;
        if (cur_f5a && p == 27) return 8'h5A;
        s = 0;
        for (int k = 0; k < cur_k * cur_k; k++) begin
            a = win_addr(p, cur_k, k);
            if (a >= 0) s += int'(img[a]);
        end
        return 8'(s / (cur_k * cur_k));
    endfunction

    // Mean-filter datapath: answers cur_dly cycles after the cycle following win_last.
    initial begin
        res_vld = 1'b0;
        res_data = 8'd0;
        forever begin
            @(negedge clk);
            res_vld = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    res_vld = 1'b1;
                    res_data = (cur_f5a && fire_idx == 27) ? 8'h5A : 8'(acc / (cur_k * cur_k));
                    pend = 0;
                end else cnt--;
            end
            if (pix_vld) begin
                if (win_start) begin acc = 0; sidx = 0; widx++; end
                acc += int'(pix_data);
                if (cur_stray && sidx == 4) begin res_vld = 1'b1; res_data = 8'hEE; end
                sidx++;
                if (win_last) begin pend = 1; cnt = cur_dly; fire_idx = widx; end
            end
        end
    end

    // Compare process: expected outputs from elapsed cycles since the accepted start.
    initial begin
        int kk, per, p, ph, a, ea;
        forever begin
            @(negedge clk);
            if (wen === 1'b1) begin
                mem[addr] = data_wr;
                wcount++;
                if (addr == 6'd20) w20++;
                if (addr == 6'd27) w27++;
            end
            if (run_on) begin
                kk = cur_k * cur_k;
                per = kk + 3 + cur_dly;
                if (t < NPIX * per) begin
                    p = t / per;
                    ph = t % per;
                    chk("busy", busy, 1);
                    chk("sel_q", sel_q, cur_sel);
                    chk("wen", wen, ph == per - 1);
                    if (ph == per - 1) begin
                        chk("addr", addr, p);
                        chk("data_wr", data_wr, exp_res(p));
                    end
                    chk("pix_vld", pix_vld, ph >= 1 && ph <= kk);
                    if (ph >= 1 && ph <= kk) begin
                        a = win_addr(p, cur_k, ph - 1);
                        chk("pix_pad", pix_pad, a < 0);
                        chk("pix_data", pix_data, (a < 0) ? 8'd0 : img[a]);
                        chk("win_start", win_start, ph == 1);
                        chk("win_last", win_last, ph == kk);
                    end
                    if (ph < kk) begin
                        ea = win_addr(p, cur_k, ph);
                        if (ea >= 0) begin
                            last_ia = ea;
                            if (p == 0) q0.push_back(int'(iaddr));
                            if (p == 27) q27.push_back(int'(iaddr));
                            chk("iaddr", iaddr, ea);
                        end else chk("iaddr_hold", iaddr, last_ia);
                    end
                    if (pix_vld && pix_pad && p == 0) pad0++;
                    if (pix_vld && pix_pad && p == NPIX - 1) pad63++;
                    t++;
                end else begin
                    chk("busy_end", busy, 0);
                    chk("wen_end", wen, 0);
                    chk("pix_vld_end", pix_vld, 0);
`ifdef IFE_SCAN_PERF_EN
                    chk("perf_cycles", perf_cycles, NPIX * per);
`endif
                    run_on = 0;
                    done = 1;
                end
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst_busy", busy, 0);       chk("rst_wen", wen, 0);
        chk("rst_pix_vld", pix_vld, 0); chk("rst_win_start", win_start, 0);
        chk("rst_win_last", win_last, 0); chk("rst_pix_pad", pix_pad, 0);
        chk("rst_iaddr", iaddr, 0);     chk("rst_addr", addr, 0);
        chk("rst_pix_data", pix_data, 0); chk("rst_data_wr", data_wr, 0);
        chk("rst_sel_q", sel_q, 0);
`ifdef IFE_SCAN_PERF_EN
        chk("rst_perf", perf_cycles, 0);
`endif
    endtask

    task automatic do_run(input logic [1:0] s, input int dly, input bit stray, input bit f5a,
                          input int abort_pix);
        int per;
        @(posedge clk); #2;
        cur_sel = s; cur_k = (s == 2'd0) ? 3 : 5; cur_dly = dly;
        cur_stray = stray; cur_f5a = f5a;
        pend = 0; widx = -1; acc = 0; sidx = 0;
        wcount = 0; w27 = 0; pad0 = 0; pad63 = 0;
        if (abort_pix >= 0) w20 = 0;
        q0.delete(); q27.delete();
        for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
        per = cur_k * cur_k + 3 + dly;
        ready = 1'b1; sel = s;
        @(posedge clk); #2;
        ready = 1'b0; sel = ~s; t = 0; done = 0; run_on = 1;
        @(posedge clk); #2; ready = 1'b1;   // must be ignored mid-run
        @(posedge clk); #2; ready = 1'b0;
        if (abort_pix >= 0) begin
            for (int i = 0; i < 20000 && t < abort_pix * per + 5; i++) @(posedge clk);
            #2; reset = 1'b1; run_on = 0;
            @(posedge clk); #2; reset = 1'b0;
            last_ia = 0;
            chk_reset_vals();
            chk("writes_before_abort", wcount, abort_pix);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("idle_busy", busy, 0);
                chk("idle_wen", wen, 0);
            end
            chk("no_write_20", w20, 0);
        end else begin
            for (int i = 0; i < 20000 && !done; i++) @(posedge clk);
            if (!done) chk("run_timeout", done, 1);
            chk("write_count", wcount, NPIX);
            for (int i = 0; i < NPIX; i++) chk("mem", mem[i], exp_res(i));
        end
    endtask

    int lit0[9]   = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int lit27[25] = '{9, 10, 11, 12, 13, 17, 18, 19, 20, 21, 25, 26, 27, 28, 29,
                      33, 34, 35, 36, 37, 41, 42, 43, 44, 45};

    initial begin
        for (int i = 0; i < NPIX; i++) img[i] = 8'((i * 29 + 7) % 256);
        reset = 1'b1; ready = 1'b0; sel = 2'd0; last_ia = 0;
        wcount = 0; w20 = 0; w27 = 0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk_reset_vals();

        // 5x5, zero latency, window 27 answered with 8'h5A
        do_run(2'd1, 0, 0, 1, -1);
        chk("q0_len", q0.size(), 9);
        for (int i = 0; i < 9 && i < q0.size(); i++) chk("q0_iaddr", q0[i], lit0[i]);
        chk("q27_len", q27.size(), 25);
        for (int i = 0; i < 25 && i < q27.size(); i++) chk("q27_iaddr", q27[i], lit27[i]);
        chk("pad_corner00_5x5", pad0, 16);
        chk("pad_corner77_5x5", pad63, 16);
        chk("writes_to_27", w27, 1);
        chk("mem27", mem[27], 8'h5A);

        // 3x3 window
        do_run(2'd0, 0, 0, 0, -1);
        chk("pad_corner00_3x3", pad0, 5);
        chk("pad_corner77_3x3", pad63, 5);

        // sel=3 selects 5x5; 10-cycle result delay plus stray res_vld during FETCH
        do_run(2'd3, 10, 1, 0, -1);

        // Reset in the middle of pixel 20, then a fresh run from addr 0
        do_run(2'd1, 0, 0, 0, 20);
        do_run(2'd1, 0, 0, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
